// File: rtl/elementwise_pkg.sv
// Shared types and defaults for the elementwise multiply sequencer.
package elementwise_pkg;

    // Sequencer phases: fill the operand buffer, run the multiplier, stream results.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int DEF_W   = 8;
    localparam int DEF_LEN = 8;

    // Width of an element index for a vector of len elements.
    function automatic int idx_w(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/mult_lane.sv
// Single W x W -> 2W unsigned multiplier lane. Kept combinational so the
// sequencer writes one product per COMPUTE cycle; a registered or DSP-mapped
// variant can replace it behind the same ports.
module mult_lane
    import elementwise_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Both operands are widened first so the full product is kept.
    assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/elementwise_mult_sequencer.sv
// Time-shared elementwise vector multiplier: loads LEN operand pairs, runs one
// multiplier lane across the buffer, then streams the LEN products out.
// Result outputs are registered; one fill cycle at DRAIN entry loads the first
// result, so the first out_valid appears LEN+1 edges after the last input.
module elementwise_mult_sequencer
    import elementwise_pkg::*;
#(
    parameter  int W   = DEF_W,
    parameter  int LEN = DEF_LEN,
    localparam int IW  = idx_w(LEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           abort,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic [IW-1:0]  out_idx,
    output logic           out_last,
    output logic           busy
);

    localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   cmp_idx;
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   rd_nxt;
    logic            ready_en;
    logic            in_fire;
    logic            out_fire;
    logic [2*W-1:0]  prod;

    logic [W-1:0]    a_buf [LEN];
    logic [W-1:0]    b_buf [LEN];
    logic [2*W-1:0]  r_buf [LEN];

    // ready_en holds in_ready low until the first edge after reset release.
    assign in_ready = (state == LOAD) && ready_en;
    assign busy     = (state != LOAD);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign rd_nxt   = rd_idx + IW'(1);

    mult_lane #(
        .W (W)
    ) u_mult (
        .a (a_buf[cmp_idx]),
        .b (b_buf[cmp_idx]),
        .p (prod)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic; abort overrides any handshake in flight.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (in_fire && (wr_idx == IDX_LAST)) state_nxt = COMPUTE;
                COMPUTE: if (cmp_idx == IDX_LAST)             state_nxt = DRAIN;
                DRAIN:   if (out_fire && out_last)            state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    // Write, compute and read indices plus the post-reset ready enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx   <= '0;
            cmp_idx  <= '0;
            rd_idx   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (abort) begin
                wr_idx  <= '0;
                cmp_idx <= '0;
                rd_idx  <= '0;
            end else begin
                if (in_fire)
                    wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + IW'(1);
                if (state == COMPUTE)
                    cmp_idx <= (cmp_idx == IDX_LAST) ? '0 : cmp_idx + IW'(1);
                if ((state == DRAIN) && out_fire)
                    rd_idx <= out_last ? '0 : rd_nxt;
            end
        end
    end

    // Operand and result buffers; data storage only, never cleared.
    always_ff @(posedge clk) begin
        if (!abort && in_fire) begin
            a_buf[wr_idx] <= in_a;
            b_buf[wr_idx] <= in_b;
        end
        if (!abort && (state == COMPUTE))
            r_buf[cmp_idx] <= prod;
    end

    // Registered result port: fill on DRAIN entry, advance on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else if (state == DRAIN) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_idx   <= rd_idx;
                out_last  <= (rd_idx == IDX_LAST);
                out_data  <= r_buf[rd_idx];
            end else if (out_ready) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_idx   <= '0;
                end else begin
                    out_idx  <= rd_nxt;
                    out_last <= (rd_nxt == IDX_LAST);
                    out_data <= r_buf[rd_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_elementwise_mult_sequencer.sv
// Directed/randomized bench for elementwise_mult_sequencer with a plain
// arithmetic reference model of the expected products.
module tb_elementwise_mult_sequencer;

    localparam int W   = 8;
    localparam int LEN = 8;
    localparam int IW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           abort;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;
    logic [IW-1:0]  out_idx;
    logic           out_last;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs_cyc;
    int va    [LEN];
    int vb    [LEN];
    int exp_r [LEN];

    elementwise_mult_sequencer #(.W(W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: each result is the plain product of its operand pair.
    function automatic void build_model();
        for (int i = 0; i < LEN; i++) exp_r[i] = va[i] * vb[i];
    endfunction

    function automatic void random_vec();
        for (int i = 0; i < LEN; i++) begin
            va[i] = int'($urandom_range(0, 255));
            vb[i] = int'($urandom_range(0, 255));
        end
        build_model();
    endfunction

    // Present the vector pair by pair, with `gap` idle cycles before each pair.
    // Starts and ends at a falling edge.
    task automatic load_vec(input int gap);
        int n;
        for (int i = 0; i < LEN; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_a = W'($urandom);
                in_b = W'($urandom);
                @(negedge clk);
            end
            check("busy_during_load", {31'd0, busy}, 32'd0);
            check("no_valid_during_load", {31'd0, out_valid}, 32'd0);
            in_valid = 1'b1;
            in_a = W'(va[i]);
            in_b = W'(vb[i]);
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        last_hs_cyc = cyc;
        check("busy_after_load", {31'd0, busy}, 32'd1);
    endtask

    // Take `count` results. mode 0: out_ready always 1; mode 1: 1,0,0,1 pattern.
    // Every visible cycle is compared, so a stall also checks that the
    // presented element stays put. Junk in_valid traffic must be ignored.
    task automatic drain(input int mode, input int count);
        int k = 0;
        int n = 0;
        int ph = 0;
        logic [3:0] pat = 4'b1001;
        while (k < count && n < 300) begin
            out_ready = (mode == 0) ? 1'b1 : pat[ph % 4];
            ph++;
            in_valid = 1'b1;
            in_a = W'($urandom);
            in_b = W'($urandom);
            if (out_valid) begin
                check("out_idx", {29'd0, out_idx}, k);
                check("out_data", {16'd0, out_data}, exp_r[k]);
                check("out_last", {31'd0, out_last}, (k == LEN - 1) ? 32'd1 : 32'd0);
                check("in_ready_in_drain", {31'd0, in_ready}, 32'd0);
                check("busy_in_drain", {31'd0, busy}, 32'd1);
                if (out_ready) k++;
            end else if (k > 0) begin
                check("valid_dropped", {31'd0, out_valid}, 32'd1);
            end
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (k < count) check("drain_timeout", k, count);
    endtask

    task automatic post_vector_checks();
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;

        // Reset values
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_idx", {29'd0, out_idx}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic vector with latency measurement
        for (int i = 0; i < LEN; i++) begin
            va[i] = i + 1;
            vb[i] = 10 * (i + 1);
        end
        build_model();
        load_vec(0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", cyc - last_hs_cyc, LEN + 1);
        drain(0, LEN);
        post_vector_checks();

        // Max operands
        for (int i = 0; i < LEN; i++) begin
            va[i] = 255;
            vb[i] = 255;
        end
        build_model();
        check("max_model", exp_r[0], 32'd65025);
        load_vec(0);
        drain(0, LEN);
        post_vector_checks();

        // Backpressure with random operands
        random_vec();
        load_vec(0);
        drain(1, LEN);
        post_vector_checks();

        // Input gaps, same operands as the basic vector
        for (int i = 0; i < LEN; i++) begin
            va[i] = i + 1;
            vb[i] = 10 * (i + 1);
        end
        build_model();
        load_vec(2);
        drain(0, LEN);
        post_vector_checks();

        // Abort in DRAIN after three results, with a simultaneous handshake
        random_vec();
        load_vec(0);
        drain(0, 3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_abort_idx", {29'd0, out_idx}, 32'd3);
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        post_vector_checks();
        check("abort_out_last", {31'd0, out_last}, 32'd0);
        for (int i = 0; i < LEN; i++) begin
            va[i] = 2;
            vb[i] = 3;
        end
        build_model();
        load_vec(1);
        drain(1, LEN);
        post_vector_checks();

        // Asynchronous reset in the middle of COMPUTE
        random_vec();
        load_vec(0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_out_idx", {29'd0, out_idx}, 32'd0);
        check("arst_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (12) begin
            @(negedge clk);
            check("arst_no_stale_valid", {31'd0, out_valid}, 32'd0);
        end
        random_vec();
        load_vec(0);
        drain(0, LEN);
        post_vector_checks();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
